// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the 8x32 FIFO and its word unpacker.
//   WORD_W          FIFO word width
//   BYTE_W          width of one byte lane on the byte stream
//   BYTES_PER_WORD  byte lanes per FIFO word
//   IDX_W           width of a byte-lane index
//   state_t         unpacker FSM encoding
//   byte_lane()     maps a transmit-order index to a physical byte lane
package fifo_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  // Transmit-order index 0 is the first byte on the wire. With msb_first the
  // first byte is the top lane, so the lane counts down from the top.
  function automatic logic [IDX_W-1:0] byte_lane(input logic [IDX_W-1:0] idx,
                                                 input logic             msb_first);
    logic [IDX_W-1:0] top;
    top = IDX_W'(BYTES_PER_WORD - 1);
    return msb_first ? (top - idx) : idx;
  endfunction

endpackage

// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: pops 32-bit words from a registered-read FIFO and emits
// each one as four bytes on a valid/ready byte stream.
//
// Parameters
//   MSB_FIRST   1: bits [31:24] go first; 0: bits [7:0] go first
// Ports
//   clk         clock, all state on posedge
//   rst         synchronous reset, active low
//   enable      allows fetching new words (never aborts a word in progress)
//   fifo_empty  FIFO empty flag, only looked at in IDLE
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  registered one-cycle pop strobe, one per word
//   byte_out    current byte (0x00 when no byte is offered)
//   byte_valid  byte_out holds a valid byte
//   byte_ready  sink accepts on byte_valid & byte_ready at posedge
//   byte_last   marks the 4th byte of a word
//   busy        registered, high in every state except IDLE
//   word_count  number of fully transmitted words, wraps at 16 bits
module fifo_word_unpacker
  import fifo_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last,
  output logic              busy,
  output logic [15:0]       word_count
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic [15:0]       r_word_count;
  logic              r_rd_en;
  logic              r_busy;

  logic              w_send;
  logic              w_hs;
  logic              w_last_idx;
  logic              w_last_hs;
  logic [IDX_W-1:0]  w_lane;

  assign w_send     = (r_state == ST_SEND);
  assign w_hs       = w_send && byte_ready;
  assign w_last_idx = (r_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign w_last_hs  = w_hs && w_last_idx;
  assign w_lane     = byte_lane(r_idx, (MSB_FIRST != 0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    byte_valid  = 1'b0;
    byte_last   = 1'b0;
    byte_out    = '0;
    case (r_state)
      // fifo_empty/enable matter only here, so a word in progress always
      // completes and a FIFO refilled during SEND is seen on return to IDLE.
      ST_IDLE: if (enable && !fifo_empty) w_state_nxt = ST_REQ;
      ST_REQ:  w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_SEND;
      ST_SEND: begin
        // Outputs depend only on state, index and shift register, none of
        // which change without a handshake, so a stall holds them stable.
        byte_valid = 1'b1;
        byte_last  = w_last_idx;
        byte_out   = r_shift[w_lane*BYTE_W +: BYTE_W];
        if (w_last_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift      <= '0;
      r_idx        <= '0;
      r_word_count <= '0;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Registered from the next state so the strobe and busy line up with
      // the state they describe rather than trailing it by a cycle.
      r_rd_en <= (w_state_nxt == ST_REQ);
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (r_state == ST_LOAD) begin
        r_shift <= fifo_data;
        r_idx   <= '0;
      end else if (w_hs) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_last_hs) begin
        r_word_count <= r_word_count + 16'd1;
      end
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign busy       = r_busy;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Bench for fifo_word_unpacker: one MSB-first and one LSB-first instance run
// in lockstep from the same stimulus, each with its own FIFO model. Words
// pushed into the FIFO models put their expected bytes into per-instance
// queues; a negedge monitor pops and compares on every handshake.
module tb_fifo_word_unpacker;
  import fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable;
  logic        byte_ready;
  logic        fifo_empty [2] = '{1'b1, 1'b1};
  logic [31:0] fifo_data  [2] = '{32'h0, 32'h0};
  logic        fifo_rd_en [2];
  logic [7:0]  byte_out   [2];
  logic        byte_valid [2];
  logic        byte_last  [2];
  logic        busy       [2];
  logic [15:0] word_count [2];

  fifo_word_unpacker #(.MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[0]),
    .fifo_data(fifo_data[0]), .fifo_rd_en(fifo_rd_en[0]), .byte_out(byte_out[0]),
    .byte_valid(byte_valid[0]), .byte_ready(byte_ready), .byte_last(byte_last[0]),
    .busy(busy[0]), .word_count(word_count[0]));

  fifo_word_unpacker #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[1]),
    .fifo_data(fifo_data[1]), .fifo_rd_en(fifo_rd_en[1]), .byte_out(byte_out[1]),
    .byte_valid(byte_valid[1]), .byte_ready(byte_ready), .byte_last(byte_last[1]),
    .busy(busy[1]), .word_count(word_count[1]));

  int n_checks = 0;
  int n_err    = 0;

  // Reference state
  logic [31:0] push_req0[$], push_req1[$];   // words offered, enter FIFO at next posedge
  logic [31:0] fq0[$], fq1[$];               // FIFO contents
  logic [8:0]  eq0[$], eq1[$];               // expected {last, byte}
  logic [15:0] wc_exp = 16'd0;
  int          sent   [2] = '{0, 0};
  int          rd_cnt [2] = '{0, 0};
  logic        prev_rd[2] = '{1'b0, 1'b0};

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int fifo_level();
    return fq0.size() + push_req0.size();
  endfunction

  task automatic push_word(input logic [31:0] w);
    push_req0.push_back(w);
    push_req1.push_back(w);
    wc_exp = wc_exp + 16'd1;
    for (int b = 0; b < 4; b++) begin
      eq0.push_back({(b == 3), w[8*(3-b) +: 8]});
      eq1.push_back({(b == 3), w[8*b +: 8]});
    end
  endtask

  // FIFO models: registered read data, one-cycle latency.
  always @(posedge clk) begin
    if (fifo_rd_en[0]) begin
      chk(!fifo_empty[0] && !prev_rd[0], "rd_en_legal_msb", {fifo_empty[0], prev_rd[0]}, 0);
      if (fq0.size() > 0) fifo_data[0] <= fq0.pop_front();
      rd_cnt[0]++;
    end
    if (fifo_rd_en[1]) begin
      chk(!fifo_empty[1] && !prev_rd[1], "rd_en_legal_lsb", {fifo_empty[1], prev_rd[1]}, 0);
      if (fq1.size() > 0) fifo_data[1] <= fq1.pop_front();
      rd_cnt[1]++;
    end
    prev_rd[0] = fifo_rd_en[0];
    prev_rd[1] = fifo_rd_en[1];
    while (push_req0.size() > 0) fq0.push_back(push_req0.pop_front());
    while (push_req1.size() > 0) fq1.push_back(push_req1.pop_front());
    fifo_empty[0] <= (fq0.size() == 0);
    fifo_empty[1] <= (fq1.size() == 0);
  end

  // Byte monitor
  logic       pv [2] = '{1'b0, 1'b0};
  logic       phs[2] = '{1'b0, 1'b0};
  logic [7:0] pb [2] = '{8'h0, 8'h0};
  logic       pl [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic       hs;
    logic       got;
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      if (rst && pv[i] && !phs[i]) begin
        chk(byte_valid[i] && byte_out[i] == pb[i] && byte_last[i] == pl[i],
            (i == 0) ? "stall_hold_msb" : "stall_hold_lsb",
            {byte_valid[i], byte_last[i], byte_out[i]}, {1'b1, pl[i], pb[i]});
      end
      hs  = rst && byte_valid[i] && byte_ready;
      got = 1'b0;
      e   = 9'h0;
      if (hs) begin
        if (i == 0 && eq0.size() > 0) begin e = eq0.pop_front(); got = 1'b1; end
        if (i == 1 && eq1.size() > 0) begin e = eq1.pop_front(); got = 1'b1; end
        chk(got && {byte_last[i], byte_out[i]} == e,
            (i == 0) ? "byte_msb" : "byte_lsb", {byte_last[i], byte_out[i]}, e);
        sent[i]++;
      end
      pv[i]  = rst && byte_valid[i];
      phs[i] = hs;
      pb[i]  = byte_out[i];
      pl[i]  = byte_last[i];
    end
  end

  task automatic check_reset_vals(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk(!fifo_rd_en[i] && !byte_valid[i] && !byte_last[i] && !busy[i] &&
          byte_out[i] == 8'h00 && word_count[i] == 16'h0000, nm,
          {fifo_rd_en[i], byte_valid[i], byte_last[i], busy[i], byte_out[i], word_count[i]}, 0);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((eq0.size() != 0 || eq1.size() != 0 || busy[0] || busy[1]) && n < 3000) begin
      tick();
      n++;
    end
    chk(n < 3000, nm, n, 3000);
    tick();
  endtask

  task automatic check_wc(input string nm);
    chk(word_count[0] == wc_exp && word_count[1] == wc_exp, nm,
        {word_count[0], word_count[1]}, {wc_exp, wc_exp});
  endtask

  task automatic wait_sent(input int target, input string nm);
    int n;
    n = 0;
    while (sent[0] < target && n < 500) begin
      tick();
      n++;
    end
    chk(n < 500, nm, sent[0], target);
  endtask

  initial begin
    int base;
    int rd0;
    rst = 1'b0; enable = 1'b0; byte_ready = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset_values");
    rst = 1'b1;

    // Latency and order: A1B2C3D4, sink always ready.
    enable = 1'b1; byte_ready = 1'b1;
    rd0 = rd_cnt[0];
    push_word(32'hA1B2C3D4);
    tick();  // fifo_empty now low: cycle 0
    chk(!fifo_rd_en[0] && !busy[0], "lat_cycle0", {fifo_rd_en[0], busy[0]}, 0);
    tick();
    chk(fifo_rd_en[0] && busy[0] && fifo_rd_en[1], "lat_req", {fifo_rd_en[0], busy[0], fifo_rd_en[1]}, 3'b111);
    tick();
    chk(!fifo_rd_en[0] && !byte_valid[0], "lat_load", {fifo_rd_en[0], byte_valid[0]}, 0);
    tick();
    chk(byte_valid[0] && byte_out[0] == 8'hA1 && byte_out[1] == 8'hD4, "lat_first_byte",
        {byte_valid[0], byte_out[0], byte_out[1]}, {1'b1, 8'hA1, 8'hD4});
    drain("drain_first");
    chk(rd_cnt[0] - rd0 == 1, "one_rd_pulse", rd_cnt[0] - rd0, 1);
    check_wc("wc_after_first");

    // Byte order the other way round shows up on the LSB instance.
    push_word(32'h11223344);
    drain("drain_order");
    check_wc("wc_after_order");

    // Backpressure on byte 2 for five cycles.
    base = sent[0];
    rd0  = rd_cnt[0];
    push_word(32'hA1B2C3D4);
    wait_sent(base + 1, "wait_byte2");
    byte_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk(byte_valid[0] && byte_out[0] == 8'hB2 && byte_out[1] == 8'hC3 && !fifo_rd_en[0],
          "backpressure_hold", {byte_valid[0], byte_out[0], byte_out[1], fifo_rd_en[0]},
          {1'b1, 8'hB2, 8'hC3, 1'b0});
      tick();
    end
    byte_ready = 1'b1;
    drain("drain_bp");
    chk(rd_cnt[0] - rd0 == 1, "bp_rd_pulses", rd_cnt[0] - rd0, 1);
    check_wc("wc_after_bp");

    // Full FIFO: eight words queued before enabling.
    enable = 1'b0;
    for (int k = 0; k < 8; k++) push_word(32'h1000_0000 * k + 32'h0102_0304 + k);
    repeat (2) tick();
    rd0 = rd_cnt[0];
    enable = 1'b1;
    drain("drain_full");
    chk(rd_cnt[0] - rd0 == 8, "full_rd_pulses", rd_cnt[0] - rd0, 8);
    chk(!busy[0] && !busy[1], "full_busy_low", {busy[0], busy[1]}, 0);
    check_wc("wc_after_full");

    // Enable dropped during byte 1 with two words queued.
    rd0  = rd_cnt[0];
    base = sent[0];
    push_word(32'hCAFE_F00D);
    push_word(32'hDEAD_BEEF);
    begin
      int n;
      n = 0;
      while (!byte_valid[0] && n < 50) begin tick(); n++; end
      chk(n < 50, "en_wait_byte1", n, 50);
    end
    enable = 1'b0;
    wait_sent(base + 4, "en_first_word_done");
    repeat (12) tick();
    chk(rd_cnt[0] - rd0 == 1, "en_no_second_req", rd_cnt[0] - rd0, 1);
    chk(fq0.size() == 1 && !busy[0], "en_word_left", {fq0.size(), busy[0]}, {32'd1, 1'b0});
    chk(word_count[0] == wc_exp - 16'd1, "en_wc", word_count[0], wc_exp - 16'd1);
    enable = 1'b1;
    drain("drain_enable");
    check_wc("wc_after_enable");

    // Reset while byte 2 is on offer.
    base = sent[0];
    push_word(32'h5566_7788);
    wait_sent(base + 1, "rst_wait_byte2");
    byte_ready = 1'b0;
    rst = 1'b0;
    tick();
    check_reset_vals("reset_mid_word");
    for (int k = 0; k < 3; k++) begin
      if (eq0.size() > 0) void'(eq0.pop_back());
      if (eq1.size() > 0) void'(eq1.pop_back());
    end
    wc_exp = 16'd0;
    rst = 1'b1; byte_ready = 1'b1;
    push_word(32'h99AA_BBCC);
    drain("drain_after_rst");
    check_wc("wc_after_rst");

    // Counter wrap.
    force dut_msb.r_word_count = 16'hFFFF;
    force dut_lsb.r_word_count = 16'hFFFF;
    tick();
    release dut_msb.r_word_count;
    release dut_lsb.r_word_count;
    tick();
    chk(word_count[0] == 16'hFFFF, "wc_preload", word_count[0], 16'hFFFF);
    wc_exp = 16'hFFFF;
    push_word(32'h0BAD_F00D);
    drain("drain_wrap");
    chk(word_count[0] == 16'h0000 && word_count[1] == 16'h0000, "wc_wrap",
        {word_count[0], word_count[1]}, 0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      byte_ready = ($urandom_range(0, 9) < 7);
      if (fifo_level() < 7 && $urandom_range(0, 9) < 3) push_word($urandom);
      tick();
    end
    byte_ready = 1'b1;
    drain("drain_random");
    check_wc("wc_after_random");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
